interp_linear: RTL
==================

Name: interp_linear

Overview:
- Linear-interpolating upsampler by R = 2^RATE_LOG2; the inverse direction of the moving-average decimator in dsp_blocks.
- Accepts unsigned low-rate samples on a valid/ready input.
- For each accepted sample, emits R output samples on a valid/ready output, ramping linearly from the previous sample toward the new one.
- Sits on the TX side of the datapath, feeding the DAC-rate chain.

Parameters:
- DATA_W, 8, sample width (unsigned).
- RATE_LOG2, 6, log2 of interpolation ratio; R = 64.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous flush; returns to IDLE and zeroes history.
- in_data  in  DATA_W  low-rate sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  DATA_W  interpolated sample, registered.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  marks beat k = R-1 of a segment.

Behaviour:
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Internal registers:
  - prev (DATA_W)
  - cur (DATA_W)
  - delta, signed DATA_W+1 = cur - prev
  - acc, signed ACC_W = DATA_W+RATE_LOG2+1
  - k (RATE_LOG2 bits)
  - state
- Reset (async): state=IDLE; prev, cur, delta, acc, k = 0; out_valid=0, out_data=0, out_last=0. in_ready forced 0 while reset is high.
- States: IDLE, RUN.
- IDLE:
  - out_valid=0; in_ready=1.
  - On input transfer: cur<=in_data; delta<=in_data-prev; acc<=prev<<RATE_LOG2; k<=0; go RUN.
- RUN:
  - out_valid=1; out_data = acc>>>RATE_LOG2 (arithmetic), truncated to DATA_W; out_last = (k==R-1).
  - Beat k value = prev + floor(delta*k/R). This always lies within [min(prev,cur), max(prev,cur)], so there is no overflow or saturation.
  - On output transfer with k<R-1: acc<=acc+delta; k<=k+1.
  - On output transfer with k==R-1: prev<=cur.
    - If an input transfer occurs in the same cycle: load the next segment using cur as the new prev (cur<=in_data; delta<=in_data-cur; acc<=cur<<RATE_LOG2; k<=0); stay RUN.
    - Otherwise go IDLE.
  - No output transfer: all state held; out_data, out_last stable.
- in_ready = !reset & (state==IDLE | (state==RUN & k==R-1 & out_ready)). This is combinational on out_ready and gives full throughput: one output per cycle, no bubble between segments.
- Latency: input accepted in cycle N gives the first output (value = prev) valid in cycle N+1. The segment ends with out_last. The new sample value itself appears as beat 0 of the following segment.
- First sample after reset or clear interpolates from prev=0.
- clear:
  - Synchronous, highest priority over both handshakes.
  - state<=IDLE; prev, cur, delta, acc, k <= 0; out_valid<=0 next cycle.
  - The in-flight segment is discarded. in_ready is not gated by clear; any input offered in the clear cycle is dropped.
- Reset mid-segment: outputs drop immediately; no partial segment resumes.
- in_valid in RUN while k<R-1: ignored (in_ready=0); the source holds data.

Decomposition:
- Package interp_pkg holds:
  - state enum {IDLE, RUN}
  - localparam functions/constants for R = 1<<RATE_LOG2 and ACC_W = DATA_W+RATE_LOG2+1
- No sub-module: counter, accumulator and FSM are tightly coupled; single module, roughly 150 lines.

Test Plan:
1. Reset, drive in_data=64 once, out_ready=1 -> 64 outputs 0,1,2,…,63; out_last only on the 64th; then out_valid=0, in_ready=1.
2. Prime with 128 and drain; then input 0 -> 128,126,124,…,2 with out_last on 2; next input 0 -> 64 outputs all 0.
3. Rounding: after 1, input 0 -> first output 1, remaining 63 outputs 0. After 0, input 1 -> all 64 outputs 0.
4. Back-to-back: in_valid held with 10,20,30, out_ready=1 -> 192 consecutive out_valid cycles, no gaps; segment boundaries at out_last; in_ready pulses exactly on each last beat.
5. Backpressure: random out_ready at 50% -> output sequence identical to test 4; out_data/out_last stable whenever out_valid & !out_ready; no input lost.
6. clear at k=20 of a 0→64 segment -> out_valid=0 next cycle; next input 64 restarts from 0, giving 0..63. Repeat with async reset at k=20 -> out_valid drops immediately; same restart.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared types and sizing helpers for the linear-interpolating upsampler.
package interp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } interp_state_t;

  function automatic int calc_r(input int rate_log2);
    return 1 << rate_log2;
  endfunction

  function automatic int calc_acc_w(input int data_w, input int rate_log2);
    return data_w + rate_log2 + 1;
  endfunction

endpackage

// File: rtl/interp_linear.sv
// Linear-interpolating upsampler: each accepted sample yields R beats ramping
// from the previous sample toward the new one, with no bubble between segments.
module interp_linear
  import interp_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int RATE_LOG2 = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int ACC_W = calc_acc_w(DATA_W, RATE_LOG2);
  localparam logic [RATE_LOG2-1:0] K_LAST = '1;

  interp_state_t            state, state_nxt;
  logic [DATA_W-1:0]        prev, prev_nxt;
  logic [DATA_W-1:0]        cur, cur_nxt;
  logic signed [DATA_W:0]   delta, delta_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [RATE_LOG2-1:0]     k, k_nxt;
  logic                     last_beat, in_xfer, out_xfer;

  function automatic logic signed [DATA_W:0] seg_delta(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  // Start value of a segment: base sample scaled into the fixed-point accumulator.
  function automatic logic signed [ACC_W-1:0] load_acc(input logic [DATA_W-1:0] base);
    return $signed({{(ACC_W-DATA_W-RATE_LOG2){1'b0}}, base, {RATE_LOG2{1'b0}}});
  endfunction

  function automatic logic signed [ACC_W-1:0] step_acc(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [DATA_W:0]  d);
    return a + $signed({{(ACC_W-DATA_W-1){d[DATA_W]}}, d});
  endfunction

  // Floor division by R; the ramp stays between its endpoints so truncation is exact.
  function automatic logic [DATA_W-1:0] acc_to_sample(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> RATE_LOG2;
    return s[DATA_W-1:0];
  endfunction

  assign last_beat = (k == K_LAST);
  assign out_valid = (state == RUN);
  assign out_last  = (state == RUN) && last_beat;
  assign out_data  = acc_to_sample(acc);
  assign in_ready  = !reset && ((state == IDLE) || ((state == RUN) && last_beat && out_ready));
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    cur_nxt   = cur;
    delta_nxt = delta;
    acc_nxt   = acc;
    k_nxt     = k;
    if (clear) begin
      state_nxt = IDLE;
      prev_nxt  = '0;
      cur_nxt   = '0;
      delta_nxt = '0;
      acc_nxt   = '0;
      k_nxt     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            cur_nxt   = in_data;
            delta_nxt = seg_delta(in_data, prev);
            acc_nxt   = load_acc(prev);
            k_nxt     = '0;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (out_xfer) begin
            if (!last_beat) begin
              acc_nxt = step_acc(acc, delta);
              k_nxt   = k + 1'b1;
            end else begin
              // Segment done: the target becomes the new history sample.
              prev_nxt = cur;
              if (in_xfer) begin
                cur_nxt   = in_data;
                delta_nxt = seg_delta(in_data, cur);
                acc_nxt   = load_acc(cur);
                k_nxt     = '0;
              end else begin
                state_nxt = IDLE;
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      prev  <= '0;
      cur   <= '0;
      delta <= '0;
      acc   <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      prev  <= prev_nxt;
      cur   <= cur_nxt;
      delta <= delta_nxt;
      acc   <= acc_nxt;
      k     <= k_nxt;
    end
  end

endmodule
